// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the regfile writeback-port arbiter.
// Round-robin priority is compiled in with WB_ARB_ROUND_ROBIN_EN.
package wb_arb_pkg;
  localparam int REG_ADDR_W      = 5;
  localparam int DEFAULT_NUM_REQ = 3;
  localparam int MAX_REQ         = 8;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcount_ge2(input logic [MAX_REQ-1:0] v);
    return |(v & (v - MAX_REQ'(1)));
  endfunction
endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// First-set search over a request vector starting at a base index, wrapping.
// A base tied to zero gives plain lowest-index-wins priority.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_base,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  int w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_base) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = IW'(w_j);
      end
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single registered regfile write port.
// Define WB_ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic                           hold,
  output logic                           WE3,
  output logic [ADDR_WIDTH-1:0]          AD3,
  output logic [DATA_WIDTH-1:0]          WD3,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           conflict_cnt
);
  localparam int IW = $clog2(NUM_REQ);

  // Handshake: a source's write transfers in the cycle where req_valid[i] and
  // req_ready[i] are both high; the source must hold rd/data stable until then.
  logic [NUM_REQ-1:0]    w_onehot;
  logic [IW-1:0]         w_idx;
  logic [IW-1:0]         w_base;
  logic                  w_any;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_data;
  logic [MAX_REQ-1:0]    w_valid8;

  logic                  r_we3;
  logic [ADDR_WIDTH-1:0] r_ad3;
  logic [DATA_WIDTH-1:0] r_wd3;
  logic [CNT_WIDTH-1:0]  r_conflict_cnt;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign w_base = r_rr_ptr;
`else
  assign w_base = '0;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req   (req_valid),
    .i_base  (w_base),
    .o_grant (w_onehot),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_grant   = !rst && !hold && w_any;
  assign req_ready = w_grant ? w_onehot : '0;
  assign w_rd      = req_rd[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_data    = req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    w_valid8                = '0;
    w_valid8[NUM_REQ-1:0]   = req_valid;
  end

  // x0 writes complete the handshake but never assert the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we3 <= 1'b0;
      r_ad3 <= '0;
      r_wd3 <= '0;
    end else if (w_grant) begin
      r_we3 <= (w_rd != '0);
      r_ad3 <= w_rd;
      r_wd3 <= w_data;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (!hold && popcount_ge2(w_valid8) && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign WE3          = r_we3;
  assign AD3          = r_ad3;
  assign WD3          = r_wd3;
  assign conflict_cnt = r_conflict_cnt;
  assign busy         = (|req_valid) || r_we3;
endmodule
